// File: rtl/onchip_mem_arbiter.sv
//==============================================================================
// Module      : onchip_mem_arbiter
// Description : Round-robin, bounded-hold arbiter sharing a single-port
//               32-bit on-chip memory between two Avalon-MM masters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module onchip_mem_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    localparam logic [3:0] c_hold_max = 4'(HOLD_MAX);

    logic              r_last_owner;
    logic [3:0]        r_hold_cnt;
    logic [1:0]        r_rd_owner_valid;
    logic [ADDR_W-1:0] r_addr_hold;

    logic              w_req0;
    logic              w_req1;
    logic              w_own_req;
    logic              w_oth_req;
    logic              w_grant;
    logic              w_win;
    logic              w_sel_read;
    logic              w_sel_write;
    logic              w_rd_grant;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // The current owner keeps the port until it has used its hold budget
    // while the other master waits; reset forces "no grant".
    always_comb begin
        w_own_req = r_last_owner ? w_req1 : w_req0;
        w_oth_req = r_last_owner ? w_req0 : w_req1;
        w_grant   = 1'b0;
        w_win     = r_last_owner;
        if (reset_n) begin
            if (w_own_req && (!w_oth_req || (r_hold_cnt < c_hold_max))) begin
                w_grant = 1'b1;
                w_win   = r_last_owner;
            end else if (w_oth_req) begin
                w_grant = 1'b1;
                w_win   = ~r_last_owner;
            end
        end
    end

    assign w_sel_read  = w_win ? m1_read    : m0_read;
    assign w_sel_write = w_win ? m1_write   : m0_write;
    assign w_sel_addr  = w_win ? m1_address : m0_address;
    // A simultaneous read+write is treated purely as a write.
    assign w_rd_grant  = w_grant & w_sel_read & ~w_sel_write;

    assign mem_address    = w_grant ? w_sel_addr : r_addr_hold;
    assign mem_byteenable = w_win ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_win ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_grant;
    assign mem_write      = w_grant & w_sel_write;
    assign mem_clken      = reset_n;

    assign m0_waitrequest = ~(w_grant & ~w_win);
    assign m1_waitrequest = ~(w_grant &  w_win);

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rd_owner_valid[0];
    assign m1_readdatavalid = r_rd_owner_valid[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner     <= 1'b0;
            r_hold_cnt       <= 4'd0;
            r_rd_owner_valid <= 2'b00;
            r_addr_hold      <= '0;
        end else begin
            r_rd_owner_valid[0] <= w_rd_grant & ~w_win;
            r_rd_owner_valid[1] <= w_rd_grant &  w_win;
            if (!w_grant) begin
                r_hold_cnt <= 4'd0;
            end else if (w_win == r_last_owner) begin
                r_addr_hold <= w_sel_addr;
                r_hold_cnt  <= (r_hold_cnt >= c_hold_max) ? c_hold_max
                                                          : r_hold_cnt + 4'd1;
            end else begin
                r_addr_hold  <= w_sel_addr;
                r_last_owner <= w_win;
                r_hold_cnt   <= 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
//==============================================================================
// Module      : tb_onchip_mem_arbiter
// Description : Scoreboard bench for onchip_mem_arbiter with a memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_onchip_mem_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int ADDR_W   = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.HOLD_MAX(HOLD_MAX), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Single-port memory: registered address, unregistered read data.
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] mem_addr_q;

    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_addr_q <= mem_address;
        end
    end
    assign mem_readdata = mem[mem_addr_q];

    // Expected grant per cycle: g = {m1 granted, m0 granted}, wr = mem_write.
    typedef struct packed {
        logic [1:0] g;
        logic       wr;
    } exp_t;

    exp_t        gq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares grants and read returns as the DUT presents them.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] d;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            check("grant", {30'd0, ~m1_waitrequest, ~m0_waitrequest}, {30'd0, e.g});
            check("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
        end
        check("dual_valid", {31'd0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
        if (m0_readdatavalid) begin
            if (rq0.size() == 0) check("m0_unexpected_valid", 32'd1, 32'd0);
            else begin
                d = rq0.pop_front();
                check("m0_readdata", m0_readdata, d);
            end
        end
        if (m1_readdatavalid) begin
            if (rq1.size() == 0) check("m1_unexpected_valid", 32'd1, 32'd0);
            else begin
                d = rq1.pop_front();
                check("m1_readdata", m1_readdata, d);
            end
        end
    end

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'h0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'h0; m1_writedata = '0;
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    // Inputs are already applied (posedge+1); queue the expectation, advance.
    task automatic step(input logic [1:0] g, input logic wr);
        exp_t e;
        e.g = g;
        e.wr = wr;
        gq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wait0"}, {31'd0, m0_waitrequest}, 32'd1);
        check({tag, "_wait1"}, {31'd0, m1_waitrequest}, 32'd1);
        check({tag, "_cs"}, {31'd0, mem_chipselect}, 32'd0);
        check({tag, "_clken"}, {31'd0, mem_clken}, 32'd0);
        check({tag, "_rdv"}, {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must be ignored.
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        set_m1(1, 1, 15'h0020, 32'h0, 4'hF);
        #3;
        check_reset_outputs("rst0");
        check("rst0_memwr", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_inputs();

        // Single write then read by m0.
        set_m0(0, 1, 15'h0010, 32'hDEADBEEF, 4'hF);
        step(2'b01, 1'b1);
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        rq0.push_back(32'hDEADBEEF);
        step(2'b01, 1'b0);
        idle_inputs();
        #3;
        check("addr_hold", {17'd0, mem_address}, 32'h0000_0010);
        step(2'b00, 1'b0);

        // Same-cycle write (m0) vs read (m1) of 0x0200: m0 owns, m1 stalls.
        set_m0(0, 1, 15'h0200, 32'h0000_0005, 4'hF);
        set_m1(1, 0, 15'h0200, 32'h0, 4'hF);
        step(2'b01, 1'b1);
        set_m0(0, 0, 15'h0, 32'h0, 4'h0);
        rq1.push_back(32'h0000_0005);
        step(2'b10, 1'b0);
        idle_inputs();
        step(2'b00, 1'b0);

        // Byte lanes on m1.
        set_m1(0, 1, 15'h0020, 32'h11223344, 4'hF);
        step(2'b10, 1'b1);
        set_m1(0, 1, 15'h0020, 32'hAABBCCDD, 4'h5);
        step(2'b10, 1'b1);
        set_m1(1, 0, 15'h0020, 32'h0, 4'hF);
        rq1.push_back(32'h11BB33DD);
        step(2'b10, 1'b0);
        idle_inputs();
        step(2'b00, 1'b0);

        // Reset, then continuous contention from the first released cycle.
        reset_n = 1'b0;
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        set_m1(1, 0, 15'h0020, 32'h0, 4'hF);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (((i / 4) % 2) != 0) begin
                rq1.push_back(32'h11BB33DD);
                step(2'b10, 1'b0);
            end else begin
                rq0.push_back(32'hDEADBEEF);
                step(2'b01, 1'b0);
            end
        end
        idle_inputs();
        step(2'b00, 1'b0);

        // Hold counter restarts after an idle cycle.
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            rq0.push_back(32'hDEADBEEF);
            step(2'b01, 1'b0);
        end
        idle_inputs();
        step(2'b00, 1'b0);
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        set_m1(0, 1, 15'h0040, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(32'hDEADBEEF);
            step(2'b01, 1'b0);
        end
        step(2'b10, 1'b1);
        idle_inputs();
        step(2'b00, 1'b0);

        // Reset asserted right after an m1 read grant drops its return.
        set_m1(1, 0, 15'h0020, 32'h0, 4'hF);
        step(2'b10, 1'b0);
        reset_n = 1'b0;
        idle_inputs();
        #3;
        check_reset_outputs("rst1");
        @(posedge clk);
        #1;
        step(2'b00, 1'b0);
        reset_n = 1'b1;
        set_m0(1, 0, 15'h0010, 32'h0, 4'hF);
        set_m1(1, 0, 15'h0040, 32'h0, 4'hF);
        rq0.push_back(32'hDEADBEEF);
        step(2'b01, 1'b0);
        rq0.push_back(32'hDEADBEEF);
        step(2'b01, 1'b0);
        idle_inputs();
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0);

        check("drain_rq0", rq0.size(), 32'd0);
        check("drain_rq1", rq1.size(), 32'd0);
        check("drain_gq", gq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
